spi_mem_ctrl: RTL and testbench
===============================

SPI_MEM_CTRL -- requirements
Module: spi_mem_ctrl

Interface
REQ-001 Parameter: ADDR_WIDTH, default 16, CPU address width (1..16), zero-extended to 16 bits on SPI.
REQ-002 Parameter: DATA_BUS_WIDTH, default 8, data width, fixed at 8.
REQ-003 clock  input  1  system clock.
REQ-004 reset  input  1  asynchronous, active-low.
REQ-005 mem_ctrl_op  input  mem_ctrl_op_e (2)  request: MEM_NOP, MEM_READ or MEM_WRITE; the unused encoding is treated as MEM_NOP.
REQ-006 addr  input  ADDR_WIDTH  target address, sampled at acceptance.
REQ-007 wdata  input  8  write data, sampled at acceptance.
REQ-008 rdata  output  8  read data, registered.
REQ-009 mem_op_done  output  1  single-cycle completion pulse.
REQ-010 spi_cs_n  output  1  SRAM chip select, active-low.
REQ-011 spi_sck  output  1  SPI clock, mode 0.
REQ-012 spi_mosi  output  1  serial data to SRAM.
REQ-013 spi_miso  input  1  serial data from SRAM.

Function
REQ-014 The block SHALL be the responder to the CPU controller's memory request protocol: the requester holds mem_ctrl_op until it sees mem_op_done.
REQ-015 FSM states SHALL be ST_IDLE, ST_SHIFT and ST_DONE.
REQ-016 In ST_IDLE, when mem_ctrl_op is MEM_READ or MEM_WRITE at a clock edge (acceptance edge E0), the block SHALL latch addr, wdata and direction, and enter ST_SHIFT.
REQ-017 ST_SHIFT SHALL transfer 32 bits MSB-first: command byte (READ 0x03, WRITE 0x02), then 16 address bits, then 8 data bits.
REQ-018 Each bit SHALL take 2 cycles:
- phase 0: spi_sck=0, spi_mosi driven with the bit;
- phase 1: spi_sck=1; spi_miso is sampled at the edge that ends phase 1.
REQ-019 spi_cs_n SHALL be 0 exactly during the 64 ST_SHIFT cycles, E0 through E0+64.
REQ-020 For reads, spi_mosi SHALL be 0 during the data byte, and the 8 sampled miso bits SHALL form rdata MSB-first.
REQ-021 For writes, miso samples SHALL be ignored and rdata SHALL be unchanged.
REQ-022 At edge E0+64 the FSM SHALL enter ST_DONE, with mem_op_done=1 for exactly one cycle, spi_cs_n=1 and spi_sck=0.
REQ-023 At edge E0+65 the FSM SHALL return to ST_IDLE.
REQ-024 rdata SHALL be valid in the ST_DONE cycle and held until the next read completes.
REQ-025 mem_ctrl_op SHALL be ignored in ST_SHIFT and ST_DONE; a change of op mid-transfer SHALL NOT abort it.
REQ-026 In the cycle after ST_DONE (ST_IDLE), mem_ctrl_op SHALL be sampled fresh, so that back-to-back operations with no NOP gap (READ then WRITE) are accepted.
REQ-027 The minimum request-to-done latency SHALL be 65 cycles after the acceptance edge, i.e. 66 cycles of op asserted including the acceptance cycle.
REQ-028 The 6-bit bit/phase counter SHALL be cleared at acceptance; it SHALL NOT wrap into a 33rd bit.

Reset
REQ-029 On reset low, the block SHALL immediately (asynchronously) set: state=ST_IDLE, spi_cs_n=1, spi_sck=0, spi_mosi=0, mem_op_done=0, rdata=0x00, counter=0, latched registers=0.
REQ-030 Reset asserted mid-transfer SHALL abort the SPI frame (cs_n deasserted) and produce no mem_op_done.
REQ-031 After reset release, the first accepted request SHALL start a complete new frame.

Structure
REQ-032 The shared package SHALL hold mem_ctrl_op_e, SPI_CMD_READ (0x03), SPI_CMD_WRITE (0x02) and the FSM state enum.
REQ-033 One sub-module, spi_shifter, SHALL contain the 32-bit shift register, the phase/bit counter and miso capture, with start/busy/last-bit handshake.
REQ-034 spi_mem_ctrl SHALL contain only the FSM, request latching and rdata.

Verification
REQ-035 Read: reset, MEM_READ, addr=0x1234, SRAM model returns 0xA5 -> MOSI stream 0x03,0x12,0x34,0x00; cs_n low 64 cycles; done at E0+64; rdata=0xA5.
REQ-036 Write: MEM_WRITE, addr=0x00FF, wdata=0x3C -> MOSI 0x02,0x00,0xFF,0x3C; model memory[0x00FF]=0x3C; rdata unchanged.
REQ-037 Back-to-back: MEM_READ done, op switches to MEM_WRITE in the next cycle with no NOP -> the write is accepted in that cycle and both frames are correct.
REQ-038 Reset mid-frame: reset asserted at bit 10 -> outputs reach reset values immediately; no done pulse; the following read of 0x0001 completes normally.
REQ-039 Protocol checks: op changed mid-frame is ignored; op encoding 2'b11 is never accepted; done is asserted only for one cycle; SCK period is 2 cycles with MOSI stable while sck=1.

Source files
------------

// File: rtl/spi_mem_ctrl_pkg.sv
// Shared types and constants for the SPI SRAM memory controller.
// Frame layout: command byte, 16 address bits, data byte, all MSB-first.
package spi_mem_ctrl_pkg;

    typedef enum logic [1:0] {
        MEM_NOP   = 2'b00,
        MEM_READ  = 2'b01,
        MEM_WRITE = 2'b10
    } mem_ctrl_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } mem_state_e;

    localparam logic [7:0] SPI_CMD_READ  = 8'h03;
    localparam logic [7:0] SPI_CMD_WRITE = 8'h02;

    // 32 bits x 2 phases; the counter value of the final (phase 1) cycle
    localparam logic [5:0] SPI_CNT_LAST = 6'd63;

    // Reads shift out zeros during the data byte
    function automatic logic [31:0] spi_frame(input logic       is_read,
                                              input logic [15:0] addr16,
                                              input logic [7:0]  data);
        logic [7:0] cmd;
        logic [7:0] tail;
        cmd  = is_read ? SPI_CMD_READ : SPI_CMD_WRITE;
        tail = is_read ? 8'h00 : data;
        return {cmd, addr16, tail};
    endfunction

endpackage

// File: rtl/spi_mem_ctrl_shifter.sv
// 32-bit SPI mode-0 frame shifter: two clocks per bit, MOSI held across both phases,
// MISO captured on the edge that ends phase 1.
module spi_shifter
    import spi_mem_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start_i,
    input  logic [31:0] frame_i,
    input  logic        spi_miso_i,
    output logic        busy_o,
    output logic        last_bit_o,
    output logic        spi_sck_o,
    output logic        spi_mosi_o,
    output logic [7:0]  rx_data_o
);

    logic [31:0] frame_q;
    logic [5:0]  cnt_q;
    logic        busy_q;
    logic        sck_q;
    logic [6:0]  rx_q;
    logic        last_bit;

    assign last_bit = busy_q && (cnt_q == SPI_CNT_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            frame_q <= 32'h0;
            cnt_q   <= 6'd0;
            busy_q  <= 1'b0;
            sck_q   <= 1'b0;
            rx_q    <= 7'h0;
        end else if (start_i) begin
            frame_q <= frame_i;
            cnt_q   <= 6'd0;
            busy_q  <= 1'b1;
            sck_q   <= 1'b0;
            rx_q    <= 7'h0;
        end else if (busy_q) begin
            // Counter LSB is the phase: next cycle is phase 1 exactly when this one is phase 0
            sck_q <= ~cnt_q[0];
            if (cnt_q[0]) begin
                frame_q <= {frame_q[30:0], 1'b0};
                rx_q    <= {rx_q[5:0], spi_miso_i};
            end
            if (last_bit) begin
                busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + 6'd1;
            end
        end
    end

    assign busy_o     = busy_q;
    assign last_bit_o = last_bit;
    assign spi_sck_o  = sck_q;
    assign spi_mosi_o = frame_q[31];
    // Includes the bit being sampled on this edge so the top can register a full byte
    assign rx_data_o  = {rx_q, spi_miso_i};

endmodule

// File: rtl/spi_mem_ctrl.sv
// Memory-request responder that performs one SPI SRAM read or write per request
// and returns a single-cycle completion pulse.
module spi_mem_ctrl
    import spi_mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned DATA_BUS_WIDTH = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  mem_ctrl_op_e              mem_ctrl_op,
    input  logic [ADDR_WIDTH-1:0]     addr,
    input  logic [DATA_BUS_WIDTH-1:0] wdata,
    output logic [DATA_BUS_WIDTH-1:0] rdata,
    output logic                      mem_op_done,
    output logic                      spi_cs_n,
    output logic                      spi_sck,
    output logic                      spi_mosi,
    input  logic                      spi_miso
);

    mem_state_e                state_q;
    logic                      cs_n_q;
    logic                      done_q;
    logic                      is_read_q;
    logic [DATA_BUS_WIDTH-1:0] rdata_q;

    logic        req_valid;
    logic        req_read;
    logic        accept;
    logic [31:0] frame;
    logic        shift_busy;
    logic        shift_last;
    logic [7:0]  shift_rx;

    // The spare op encoding falls into the default arm and is never accepted
    always_comb begin
        req_valid = 1'b0;
        req_read  = 1'b0;
        case (mem_ctrl_op)
            MEM_READ: begin
                req_valid = 1'b1;
                req_read  = 1'b1;
            end
            MEM_WRITE: req_valid = 1'b1;
            default:   req_valid = 1'b0;
        endcase
    end

    assign accept = (state_q == ST_IDLE) && req_valid;
    assign frame  = spi_frame(req_read, 16'(addr), 8'(wdata));

    spi_shifter u_shifter (
        .clock      (clock),
        .reset      (reset),
        .start_i    (accept),
        .frame_i    (frame),
        .spi_miso_i (spi_miso),
        .busy_o     (shift_busy),
        .last_bit_o (shift_last),
        .spi_sck_o  (spi_sck),
        .spi_mosi_o (spi_mosi),
        .rx_data_o  (shift_rx)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cs_n_q    <= 1'b1;
            done_q    <= 1'b0;
            is_read_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        state_q   <= ST_SHIFT;
                        cs_n_q    <= 1'b0;
                        is_read_q <= req_read;
                    end
                end
                ST_SHIFT: begin
                    if (shift_last) begin
                        state_q <= ST_DONE;
                        cs_n_q  <= 1'b1;
                        done_q  <= 1'b1;
                        if (is_read_q) begin
                            rdata_q <= DATA_BUS_WIDTH'(shift_rx);
                        end
                    end else if (!shift_busy) begin
                        // Shifter lost its frame without finishing: drop back quietly
                        state_q <= ST_IDLE;
                        cs_n_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    cs_n_q  <= 1'b1;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rdata       = rdata_q;
    assign mem_op_done = done_q;
    assign spi_cs_n    = cs_n_q;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Directed bench for spi_mem_ctrl with a behavioural SPI SRAM model and
// protocol monitors on the SPI pins.
module tb_spi_mem_ctrl;
    import spi_mem_ctrl_pkg::*;

    logic         clock = 1'b0;
    logic         reset;
    mem_ctrl_op_e mem_ctrl_op;
    logic [15:0]  addr;
    logic [7:0]   wdata;
    logic [7:0]   rdata;
    logic         mem_op_done;
    logic         spi_cs_n;
    logic         spi_sck;
    logic         spi_mosi;
    logic         spi_miso;

    int checks   = 0;
    int failures = 0;

    spi_mem_ctrl #(
        .ADDR_WIDTH     (16),
        .DATA_BUS_WIDTH (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .mem_ctrl_op (mem_ctrl_op),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .mem_op_done (mem_op_done),
        .spi_cs_n    (spi_cs_n),
        .spi_sck     (spi_sck),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso)
    );

    always #5 clock = ~clock;

    // SPI SRAM model: samples MOSI on SCK rise, updates MISO after SCK fall
    logic [7:0]  mem [0:65535];
    int          m_bit = 0;
    int          m_nsamp = 0;
    int          m_last_n = 0;
    logic [31:0] m_frame = 32'h0;
    logic [31:0] m_last_frame = 32'h0;
    logic [7:0]  m_cmd = 8'h0;
    logic [15:0] m_addr = 16'h0;
    logic [7:0]  m_tx = 8'h0;
    logic        p_sck = 1'b0;
    logic        p_cs = 1'b1;

    always @(spi_sck or spi_cs_n) begin
        if (spi_cs_n === 1'b0 && p_cs !== 1'b0) begin
            m_bit = 0;
            m_nsamp = 0;
            m_frame = 32'h0;
            m_cmd = 8'h0;
            m_tx = 8'h0;
        end else if (spi_cs_n === 1'b1 && p_cs === 1'b0) begin
            m_last_frame = m_frame;
            m_last_n = m_nsamp;
            if (m_nsamp == 32 && m_frame[31:24] == 8'h02) mem[m_frame[23:8]] = m_frame[7:0];
            m_tx = 8'h0;
        end else if (spi_cs_n === 1'b0) begin
            if (spi_sck === 1'b1 && p_sck !== 1'b1) begin
                m_frame = {m_frame[30:0], spi_mosi};
                m_nsamp++;
                if (m_nsamp == 24) begin
                    m_cmd = m_frame[23:16];
                    m_addr = m_frame[15:0];
                end
            end else if (spi_sck === 1'b0 && p_sck === 1'b1) begin
                m_bit++;
                // Writes see junk on MISO so a design that captures it would be caught
                if (m_bit == 24) m_tx = (m_cmd == 8'h03) ? mem[m_addr] : 8'h5A;
                else if (m_bit > 24) m_tx = {m_tx[6:0], 1'b0};
            end
        end
        p_sck = spi_sck;
        p_cs = spi_cs_n;
    end

    assign spi_miso = m_tx[7];

    // Pin monitors; the tasks compare their counters
    int   done_count = 0;
    int   done_viol = 0;
    int   sck_viol = 0;
    int   mosi_viol = 0;
    logic prev_done = 1'b0;
    logic prev_sck = 1'b0;
    logic prev_cs = 1'b1;
    logic prev_mosi = 1'b0;

    always @(negedge clock) begin
        if (mem_op_done === 1'b1) begin
            done_count++;
            if (prev_done === 1'b1) done_viol++;
        end
        if (spi_sck === 1'b1 && (prev_sck === 1'b1 || spi_cs_n !== 1'b0)) sck_viol++;
        if (spi_cs_n === 1'b0 && prev_cs === 1'b0 && spi_sck === 1'b0 && prev_sck === 1'b0)
            sck_viol++;
        if (spi_sck === 1'b1 && spi_mosi !== prev_mosi) mosi_viol++;
        prev_done = mem_op_done;
        prev_sck = spi_sck;
        prev_cs = spi_cs_n;
        prev_mosi = spi_mosi;
    end

    // Drives one request from the current negedge and reports negedge indices of
    // the first chip-select-low cycle and of the done pulse (-1 if not seen).
    task automatic do_op(input mem_ctrl_op_e op, input logic [15:0] a, input logic [7:0] d,
                         input int chg_n, input mem_ctrl_op_e chg_op,
                         output int cs_at, output int done_at);
        int n;
        n = 0;
        cs_at = -1;
        done_at = -1;
        mem_ctrl_op = op;
        addr = a;
        wdata = d;
        while (n < 200 && done_at < 0) begin
            @(negedge clock);
            n++;
            if (n == chg_n) mem_ctrl_op = chg_op;
            if (spi_cs_n === 1'b0 && cs_at < 0) cs_at = n;
            if (mem_op_done === 1'b1) done_at = n;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        mem_ctrl_op = MEM_NOP;
        addr = 16'h0;
        wdata = 8'h0;
        repeat (3) @(negedge clock);
        checks++; if (spi_cs_n !== 1'b1) begin failures++; $display("FAIL reset_cs_n: got %b want 1", spi_cs_n); end
        checks++; if (spi_sck !== 1'b0) begin failures++; $display("FAIL reset_sck: got %b want 0", spi_sck); end
        checks++; if (spi_mosi !== 1'b0) begin failures++; $display("FAIL reset_mosi: got %b want 0", spi_mosi); end
        checks++; if (mem_op_done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", mem_op_done); end
        checks++; if (rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata: got %h want 00", rdata); end
        reset = 1'b1;
        repeat (2) @(negedge clock);
        checks++; if (spi_cs_n !== 1'b1) begin failures++; $display("FAIL idle_cs_n: got %b want 1", spi_cs_n); end
    endtask

    task automatic test_read;
        int cs_at, done_at;
        mem[16'h1234] = 8'hA5;
        do_op(MEM_READ, 16'h1234, 8'h00, 0, MEM_READ, cs_at, done_at);
        checks++; if (done_at != 65) begin failures++; $display("FAIL read_latency: got %0d want 65", done_at); end
        checks++; if (done_at - cs_at != 64) begin failures++; $display("FAIL read_cs_low: got %0d want 64", done_at - cs_at); end
        checks++; if (spi_cs_n !== 1'b1 || spi_sck !== 1'b0) begin failures++; $display("FAIL read_done_pins: got cs_n=%b sck=%b want 1 0", spi_cs_n, spi_sck); end
        checks++; if (rdata !== 8'hA5) begin failures++; $display("FAIL read_rdata: got %h want a5", rdata); end
        checks++; if (m_last_frame !== 32'h03123400) begin failures++; $display("FAIL read_mosi: got %h want 03123400", m_last_frame); end
        checks++; if (m_last_n != 32) begin failures++; $display("FAIL read_bits: got %0d want 32", m_last_n); end
        mem_ctrl_op = MEM_NOP;
        @(negedge clock);
        checks++; if (mem_op_done !== 1'b0) begin failures++; $display("FAIL read_done_width: got %b want 0", mem_op_done); end
        checks++; if (rdata !== 8'hA5) begin failures++; $display("FAIL read_rdata_hold: got %h want a5", rdata); end
    endtask

    task automatic test_write;
        int cs_at, done_at;
        do_op(MEM_WRITE, 16'h00FF, 8'h3C, 0, MEM_WRITE, cs_at, done_at);
        mem_ctrl_op = MEM_NOP;
        checks++; if (done_at != 65) begin failures++; $display("FAIL write_latency: got %0d want 65", done_at); end
        checks++; if (m_last_frame !== 32'h0200FF3C) begin failures++; $display("FAIL write_mosi: got %h want 0200ff3c", m_last_frame); end
        checks++; if (mem[16'h00FF] !== 8'h3C) begin failures++; $display("FAIL write_mem: got %h want 3c", mem[16'h00FF]); end
        checks++; if (rdata !== 8'hA5) begin failures++; $display("FAIL write_rdata_unchanged: got %h want a5", rdata); end
        @(negedge clock);
    endtask

    task automatic test_back_to_back;
        int cs_at, done_at;
        mem[16'h0042] = 8'h96;
        do_op(MEM_READ, 16'h0042, 8'h00, 0, MEM_READ, cs_at, done_at);
        checks++; if (done_at != 65) begin failures++; $display("FAIL b2b_read_latency: got %0d want 65", done_at); end
        checks++; if (rdata !== 8'h96) begin failures++; $display("FAIL b2b_read_rdata: got %h want 96", rdata); end
        checks++; if (m_last_frame !== 32'h03004200) begin failures++; $display("FAIL b2b_read_mosi: got %h want 03004200", m_last_frame); end
        // Write presented in the done cycle: one idle cycle, then acceptance
        do_op(MEM_WRITE, 16'h0100, 8'h77, 0, MEM_WRITE, cs_at, done_at);
        mem_ctrl_op = MEM_NOP;
        checks++; if (done_at != 66) begin failures++; $display("FAIL b2b_write_latency: got %0d want 66", done_at); end
        checks++; if (m_last_frame !== 32'h02010077) begin failures++; $display("FAIL b2b_write_mosi: got %h want 02010077", m_last_frame); end
        checks++; if (mem[16'h0100] !== 8'h77) begin failures++; $display("FAIL b2b_write_mem: got %h want 77", mem[16'h0100]); end
        checks++; if (rdata !== 8'h96) begin failures++; $display("FAIL b2b_rdata_hold: got %h want 96", rdata); end
        @(negedge clock);
    endtask

    task automatic test_op_change;
        int cs_at, done_at;
        mem[16'h0010] = 8'hC3;
        do_op(MEM_READ, 16'h0010, 8'h00, 20, MEM_WRITE, cs_at, done_at);
        mem_ctrl_op = MEM_NOP;
        checks++; if (done_at != 65) begin failures++; $display("FAIL chg_read_latency: got %0d want 65", done_at); end
        checks++; if (m_last_frame !== 32'h03001000) begin failures++; $display("FAIL chg_read_mosi: got %h want 03001000", m_last_frame); end
        checks++; if (rdata !== 8'hC3) begin failures++; $display("FAIL chg_read_rdata: got %h want c3", rdata); end
        @(negedge clock);
        do_op(MEM_WRITE, 16'h0020, 8'h11, 30, mem_ctrl_op_e'(2'b11), cs_at, done_at);
        mem_ctrl_op = MEM_NOP;
        checks++; if (done_at != 65) begin failures++; $display("FAIL chg_write_latency: got %0d want 65", done_at); end
        checks++; if (mem[16'h0020] !== 8'h11) begin failures++; $display("FAIL chg_write_mem: got %h want 11", mem[16'h0020]); end
        @(negedge clock);
    endtask

    task automatic test_illegal_op;
        int lows;
        lows = 0;
        mem_ctrl_op = mem_ctrl_op_e'(2'b11);
        addr = 16'h1234;
        repeat (20) begin
            @(negedge clock);
            if (spi_cs_n !== 1'b1 || mem_op_done !== 1'b0) lows++;
        end
        mem_ctrl_op = MEM_NOP;
        checks++; if (lows != 0) begin failures++; $display("FAIL illegal_op_accepted: got %0d active cycles want 0", lows); end
    endtask

    task automatic test_reset_mid;
        int cs_at, done_at, dc0;
        dc0 = done_count;
        mem_ctrl_op = MEM_READ;
        addr = 16'h3FFF;
        // Negedge 22 lands in bit 10 phase 1, where MOSI carries addr[13]=1
        repeat (22) @(negedge clock);
        checks++; if (spi_cs_n !== 1'b0 || spi_sck !== 1'b1 || spi_mosi !== 1'b1) begin
            failures++; $display("FAIL mid_frame_pins: got cs_n=%b sck=%b mosi=%b want 0 1 1", spi_cs_n, spi_sck, spi_mosi);
        end
        #2 reset = 1'b0;
        #1;
        checks++; if (spi_cs_n !== 1'b1) begin failures++; $display("FAIL async_cs_n: got %b want 1", spi_cs_n); end
        checks++; if (spi_sck !== 1'b0 || spi_mosi !== 1'b0) begin failures++; $display("FAIL async_sck_mosi: got %b %b want 0 0", spi_sck, spi_mosi); end
        checks++; if (rdata !== 8'h00 || mem_op_done !== 1'b0) begin failures++; $display("FAIL async_rdata_done: got %h %b want 00 0", rdata, mem_op_done); end
        mem_ctrl_op = MEM_NOP;
        repeat (5) @(negedge clock);
        checks++; if (done_count != dc0) begin failures++; $display("FAIL abort_done: got %0d pulses want %0d", done_count, dc0); end
        reset = 1'b1;
        @(negedge clock);
        mem[16'h0001] = 8'h5E;
        do_op(MEM_READ, 16'h0001, 8'h00, 0, MEM_READ, cs_at, done_at);
        mem_ctrl_op = MEM_NOP;
        checks++; if (done_at != 65) begin failures++; $display("FAIL post_reset_latency: got %0d want 65", done_at); end
        checks++; if (m_last_frame !== 32'h03000100) begin failures++; $display("FAIL post_reset_mosi: got %h want 03000100", m_last_frame); end
        checks++; if (rdata !== 8'h5E) begin failures++; $display("FAIL post_reset_rdata: got %h want 5e", rdata); end
        @(negedge clock);
    endtask

    task automatic test_protocol;
        checks++; if (done_count != 7) begin failures++; $display("FAIL done_total: got %0d want 7", done_count); end
        checks++; if (done_viol != 0) begin failures++; $display("FAIL done_width: got %0d long pulses want 0", done_viol); end
        checks++; if (sck_viol != 0) begin failures++; $display("FAIL sck_period: got %0d violations want 0", sck_viol); end
        checks++; if (mosi_viol != 0) begin failures++; $display("FAIL mosi_stable: got %0d violations want 0", mosi_viol); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_op_change();
        test_illegal_op();
        test_reset_mid();
        test_protocol();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
